clock_display_scan: RTL and testbench

Downstream consumer of the digital clock counter. Takes the binary `minutes`/`seconds` values and drives a 4-digit, time-multiplexed, common-anode seven-segment display, with a colon that blinks at 1 Hz. Inputs are snapshotted once per scan frame so a digit pair never shows a torn value. All outputs are registered.

---
 rtl/clock_display_scan_pkg.sv | 16 +
 rtl/clock_display_scan_seg7_encode.sv | 19 +
 rtl/clock_display_scan.sv | 105 ++++++++++
 tb/tb_clock_display_scan.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/clock_display_scan_pkg.sv
// Shared types and seven-segment codes for the clock display scanner.
package clock_disp_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [1:0] digit_idx_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam seg7_t SEG_DASH = 7'h40;

  localparam logic [5:0] FIELD_MAX = 6'd59;

endpackage

// File: rtl/clock_display_scan_seg7_encode.sv
// Combinational BCD digit to seven-segment encoder; dash overrides the digit.
module seg7_encode
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_dash,
  output seg7_t      o_seg
);

  always_comb begin
    o_seg = 7'h00;
    if (i_dash) begin
      o_seg = SEG_DASH;
    end else if (i_bcd <= 4'd9) begin
      o_seg = SEG_DIGIT[i_bcd];
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// Four-digit multiplexed MM:SS display scanner with blinking colon.
// Optional leading-zero blanking of the minutes tens digit: CLOCK_DISP_LZ_BLANK_EN.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_idx;
  logic [5:0]       r_snap_sec;
  logic [5:0]       r_snap_min;
  seg7_t            r_seg;
  logic [3:0]       r_an;
  logic             r_dp;

  logic       w_tc;
  logic       w_sec_oor;
  logic       w_min_oor;
  logic [3:0] w_sec_tens;
  logic [3:0] w_sec_ones;
  logic [3:0] w_min_tens;
  logic [3:0] w_min_ones;
  logic [3:0] w_digit;
  logic       w_dash;
  logic       w_blank;
  seg7_t      w_seg;

  assign w_tc      = (r_cnt == CNT_LAST);
  assign w_sec_oor = (r_snap_sec > FIELD_MAX);
  assign w_min_oor = (r_snap_min > FIELD_MAX);

  assign w_sec_tens = 4'(r_snap_sec / 6'd10);
  assign w_sec_ones = 4'(r_snap_sec % 6'd10);
  assign w_min_tens = 4'(r_snap_min / 6'd10);
  assign w_min_ones = 4'(r_snap_min % 6'd10);

  always_comb begin
    w_digit = w_sec_ones;
    w_dash  = w_sec_oor;
    case (r_idx)
      2'd0: begin w_digit = w_sec_ones; w_dash = w_sec_oor; end
      2'd1: begin w_digit = w_sec_tens; w_dash = w_sec_oor; end
      2'd2: begin w_digit = w_min_ones; w_dash = w_min_oor; end
      2'd3: begin w_digit = w_min_tens; w_dash = w_min_oor; end
      default: ;
    endcase
  end

`ifdef CLOCK_DISP_LZ_BLANK_EN
  // A dash is never blanked, hence the range check.
  assign w_blank = (r_idx == 2'd3) && (w_min_tens == 4'd0) && !w_min_oor;
`else
  assign w_blank = 1'b0;
`endif

  seg7_encode u_enc (
    .i_bcd  (w_digit),
    .i_dash (w_dash),
    .o_seg  (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_snap_sec <= 6'd0;
      r_snap_min <= 6'd0;
      r_seg      <= 7'h00;
      r_an       <= 4'b1111;
      r_dp       <= 1'b0;
    end else begin
      r_seg <= w_blank ? 7'h00 : w_seg;
      r_an  <= w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
      r_dp  <= (r_idx == 2'd2) && !w_sec_oor && !r_snap_sec[0];
      if (w_tc) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
        // Snapshot only at frame wrap so a digit pair never tears.
        if (r_idx == 2'd3) begin
          r_snap_sec <= seconds;
          r_snap_min <= minutes;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = r_dp;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan at REFRESH_DIV=4.
module tb_clock_display_scan;

  logic       clk;
  logic       reset;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;

`ifdef CLOCK_DISP_LZ_BLANK_EN
  localparam logic [3:0] LZ_AN  = 4'b1111;
  localparam logic [6:0] LZ_SEG = 7'h00;
`else
  localparam logic [3:0] LZ_AN  = 4'b0111;
  localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

  clock_display_scan #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .seconds (seconds),
    .minutes (minutes),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
        n_fail++;
        $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 e.name, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [5:0] s, input logic [5:0] m,
                     input logic [3:0] ea, input logic [6:0] es, input logic ed,
                     input string nm);
    reset   = rst;
    seconds = s;
    minutes = m;
    q.push_back('{an: ea, seg: es, dp: ed, name: nm});
    n_pushed++;
    @(negedge clk);
  endtask

  task automatic slot(input logic [5:0] s, input logic [5:0] m,
                      input logic [3:0] ea, input logic [6:0] es, input logic ed,
                      input string nm);
    repeat (4) cyc(1'b1, s, m, ea, es, ed, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    seconds = 6'd34;
    minutes = 6'd12;
    @(negedge clk);

    repeat (5) cyc(1'b0, 6'd34, 6'd12, 4'b1111, 7'h00, 1'b0, "reset");

    n_tests++;
    if (an !== 4'b1111 || seg !== 7'h00 || dp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_direct: got an=%b seg=%h dp=%b", an, seg, dp);
    end

    // Frame 0: snapshot cleared, shows 00:00; seconds 0 is even so colon lit.
    slot(6'd34, 6'd12, 4'b1110, 7'h3F, 1'b0, "f0_s0");
    slot(6'd34, 6'd12, 4'b1101, 7'h3F, 1'b0, "f0_s1");
    slot(6'd34, 6'd12, 4'b1011, 7'h3F, 1'b1, "f0_s2");
    slot(6'd34, 6'd12, LZ_AN,   LZ_SEG, 1'b0, "f0_s3");

    // Frame 1: 12:34.
    slot(6'd34, 6'd12, 4'b1110, 7'h66, 1'b0, "f1_s0");
    slot(6'd34, 6'd12, 4'b1101, 7'h4F, 1'b0, "f1_s1");
    slot(6'd34, 6'd12, 4'b1011, 7'h5B, 1'b1, "f1_s2");
    slot(6'd34, 6'd12, 4'b0111, 7'h06, 1'b0, "f1_s3");

    // Frame 2: inputs change to 12:35 at idx 1, frame keeps 12:34.
    slot(6'd34, 6'd12, 4'b1110, 7'h66, 1'b0, "f2_s0");
    slot(6'd35, 6'd12, 4'b1101, 7'h4F, 1'b0, "f2_s1_midchg");
    slot(6'd35, 6'd12, 4'b1011, 7'h5B, 1'b1, "f2_s2_midchg");
    slot(6'd35, 6'd12, 4'b0111, 7'h06, 1'b0, "f2_s3");

    // Frame 3: 12:35, odd seconds so colon off.
    slot(6'd35, 6'd12, 4'b1110, 7'h6D, 1'b0, "f3_s0_new");
    slot(6'd35, 6'd12, 4'b1101, 7'h4F, 1'b0, "f3_s1");
    slot(6'd35, 6'd12, 4'b1011, 7'h5B, 1'b0, "f3_s2_odd");
    slot(6'd61, 6'd7,  4'b0111, 7'h06, 1'b0, "f3_s3");

    // Frame 4: seconds 61 out of range, minutes 07.
    slot(6'd61, 6'd7,  4'b1110, 7'h40, 1'b0, "f4_s0_dash");
    slot(6'd61, 6'd7,  4'b1101, 7'h40, 1'b0, "f4_s1_dash");
    slot(6'd61, 6'd7,  4'b1011, 7'h07, 1'b0, "f4_s2_oor_dp");
    slot(6'd20, 6'd5,  LZ_AN,   LZ_SEG, 1'b0, "f4_s3_lz");

    // Frame 5: 05:20.
    slot(6'd20, 6'd5,  4'b1110, 7'h3F, 1'b0, "f5_s0");
    slot(6'd20, 6'd5,  4'b1101, 7'h5B, 1'b0, "f5_s1");
    slot(6'd20, 6'd5,  4'b1011, 7'h6D, 1'b1, "f5_s2");
    slot(6'd20, 6'd5,  LZ_AN,   LZ_SEG, 1'b0, "f5_s3_lz");

    // Frame 6: reset pulse while idx 2, then a fresh frame from cleared snapshot.
    slot(6'd20, 6'd5,  4'b1110, 7'h3F, 1'b0, "f6_s0");
    slot(6'd20, 6'd5,  4'b1101, 7'h5B, 1'b0, "f6_s1");
    cyc(1'b1, 6'd20, 6'd5, 4'b1011, 7'h6D, 1'b1, "f6_s2");
    cyc(1'b0, 6'd20, 6'd5, 4'b1111, 7'h00, 1'b0, "rst_mid");
    slot(6'd20, 6'd5,  4'b1110, 7'h3F, 1'b0, "post_rst_s0");
    slot(6'd20, 6'd5,  4'b1101, 7'h3F, 1'b0, "post_rst_s1");
    slot(6'd20, 6'd5,  4'b1011, 7'h3F, 1'b1, "post_rst_s2");

    n_tests++;
    if (an !== 4'b1011 || seg !== 7'h3F || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_direct: got an=%b seg=%h dp=%b", an, seg, dp);
    end

    @(posedge clk);
    #2;
    if (n_tests != n_pushed + 2) begin
      n_fail++;
      $display("FAIL scoreboard: %0d pushed, %0d checked", n_pushed, n_tests - 2);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
